md_unit: RTL
============

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with architectural HI/LO registers, fed by E-stage forwarded operands.
//  Executes MULT/MULTU/DIV/DIVU with fixed latency and MTHI/MTLO in one cycle.
//  HI/LO feed the M/W result muxes for MFHI/MFLO.
//  busy/start are used by D-stage hazard logic to stall any later MD-class instruction.
// PARAMETERS
//  MUL_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES  10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1   rising-edge clock
//  reset   in   1   asynchronous, active-low reset
//  start   in   1   one-cycle request; valid only when the E-stage instruction is MD-class
//  op      in   4   1=MULT 2=MULTU 3=DIV 4=DIVU 7=MTHI 8=MTLO; other codes are no-ops
//  d1      in   32  rs operand: multiplicand / dividend / MT source
//  d2      in   32  rt operand: multiplier / divisor
//  hi      out  32  HI register
//  lo      out  32  LO register
//  busy    out  1   operation in flight
//  cancel  in   1   present only with MDU_CANCEL_EN
// BEHAVIOUR
//  Reset (async, reset==0): hi=0, lo=0, busy=0, state=IDLE, counter=0. Any in-flight op is discarded.
//  States and transitions:
//   - IDLE -> MUL on start with op in {1,2}.
//   - IDLE -> DIV on start with op in {3,4}.
//   - MUL/DIV -> IDLE when the counter reaches its cycle count.
//  Start-edge actions (start at edge t, op 1-4):
//   - Operands and op are latched; the full result is computed into pending regs.
//   - busy=1 from cycle t+1 through t+N, with N = MUL_CYCLES or DIV_CYCLES.
//   - hi/lo are committed at the edge ending cycle t+N; new values are visible when busy falls.
//  MTHI/MTLO: with start=1 in IDLE, hi (resp. lo) = d1 at the next edge; busy stays 0.
//  Start while busy: ignored (the hazard unit stalls). hi/lo and the in-flight op are unaffected.
//  Start with op not in {1,2,3,4,7,8}: no-op.
//  Arithmetic:
//   - MULT: {hi,lo} = $signed(d1)*$signed(d2), 64-bit.
//   - MULTU: same, unsigned.
//   - DIV: lo = quotient truncated toward zero; hi = remainder, sign of the dividend.
//   - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//   - DIVU: unsigned quotient in lo, remainder in hi.
//   - Divisor==0 (DIV or DIVU): the op still runs DIV_CYCLES with busy=1; hi/lo are left UNCHANGED.
//  hi/lo change only on a commit edge or an MTHI/MTLO edge; they are stable at all other times.
// CONFIGURATION
//  MDU_CANCEL_EN defined:
//   - Adds the cancel port.
//   - cancel=1 while busy: returns to IDLE at the next edge with busy=0; pending result discarded; hi/lo unchanged.
//   - cancel has priority over commit on the final cycle.
//   - cancel in IDLE also suppresses a same-cycle start or MTHI/MTLO.
//  MDU_CANCEL_EN undefined: the cancel port is absent and every started op always commits.
// STRUCTURE
//  Shared package md_pkg:
//   - op codes MD_MULT..MD_MTLO (4-bit localparams);
//   - state encoding MD_IDLE/MD_MUL/MD_DIV;
//   - default cycle counts.
//  Sub-module md_calc: combinational 64-bit product and quotient/remainder for a given op, including the zero-divisor flag.
//  md_unit holds the FSM, counter, pending regs and HI/LO.
// TESTING
//  1. start, op=MULT, d1=0xFFFFFFFD, d2=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2. MULTU d1=0xFFFFFFFF, d2=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
//  3. DIV d1=0xFFFFFFF9 (-7), d2=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  4. Divide by zero: preload MTHI 0x1234, MTLO 0x5678; DIVU d2=0 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
//  5. Start while busy:
//     - MULT 3*4; at busy cycle 2 pulse start op=MTLO d1=9.
//     - Required: ignored, final lo=12, hi=0.
//  6. Reset mid-operation:
//     - DIV in flight; drive reset low asynchronously between edges.
//     - Required: busy=0, hi=lo=0 immediately; no commit after reset release.
//     - With MDU_CANCEL_EN: cancel at busy cycle 3 -> busy=0 next cycle, hi/lo unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state encoding,
// default latencies and small op-class helpers.
package md_pkg;

  // Op codes as presented by the E stage. The signed divide is MD_DIVS because
  // MD_DIV names the divide state of the FSM.
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIVS  = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_t;

  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIVS) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic core: 64-bit product or quotient/remainder for one op,
// plus a zero-divisor flag.
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        mul_signed;
  logic        neg_a;
  logic        neg_b;
  logic [63:0] prod;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    mul_signed = (op == MD_MULT);
    // Sign-extending both factors makes one 64x64 multiplier serve MULT and MULTU.
    prod = {{32{mul_signed & a[31]}}, a} * {{32{mul_signed & b[31]}}, b};

    // Signed divide runs on magnitudes; 0x80000000 / -1 then falls out as 0x80000000 rem 0.
    neg_a    = (op == MD_DIVS) & a[31];
    neg_b    = (op == MD_DIVS) & b[31];
    abs_a    = neg_a ? -a : a;
    abs_b    = neg_b ? -b : b;
    div_zero = (b == 32'd0);
    div_b    = div_zero ? 32'd1 : abs_b;
    q_mag    = abs_a / div_b;
    r_mag    = abs_a % div_b;

    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div_op(op)) begin
      res_lo = (neg_a ^ neg_b) ? -q_mag : q_mag;
      res_hi = neg_a ? -r_mag : r_mag;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MDU_CANCEL_EN adds a cancel input that aborts an in-flight op.
module md_unit
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a single-cycle request sampled only in IDLE. An accepted
  // MULT/DIV raises busy on the next edge and holds it for exactly N cycles; HI/LO
  // update on the edge where busy falls. Starts seen while busy are dropped, since
  // the D-stage hazard logic is expected to stall them.
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_target;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_skip;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             div_zero;
  logic             cancel_req;

`ifdef MDU_CANCEL_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
`endif

  md_calc u_calc (
    .op       (op),
    .a        (d1),
    .b        (d2),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign cnt_target = (state == MD_MUL) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_skip <= 1'b0;
    end else if (cancel_req) begin
      // Cancel wins over both a same-cycle start and a final-cycle commit.
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            if (is_mul_op(op) || is_div_op(op)) begin
              state     <= is_mul_op(op) ? MD_MUL : MD_DIV;
              cnt       <= CNT_W'(1);
              busy      <= 1'b1;
              pend_hi   <= res_hi;
              pend_lo   <= res_lo;
              pend_skip <= is_div_op(op) & div_zero;
            end else if (op == MD_MTHI) begin
              hi <= d1;
            end else if (op == MD_MTLO) begin
              lo <= d1;
            end
          end
        end
        default: begin
          if (cnt == cnt_target) begin
            state <= MD_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            // A zero divisor occupies the unit for the full latency but leaves HI/LO intact.
            if (!pend_skip) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
